ofm_stream_reader: RTL and testbench

- Drains the finished output feature map (OFM) from port B of the OFM dual-port RAM once the systolic-array controller has finished.
- Packs consecutive 16-bit signed results into INOUT_WIDTH-bit beats and sends them on a valid/ready stream toward the host/DMA side.
- It is the read-side counterpart of the array's OFM write path, and replaces file dumping as the way results leave the chip.

---
 rtl/ofm_stream_reader.sv | 154 +++++++++++++++
 tb/tb_ofm_stream_reader.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/ofm_stream_reader.sv
// ofm_stream_reader: drains the finished OFM from RAM port B, packs 16-bit
// words into INOUT_WIDTH-bit beats and emits them on a valid/ready stream.
// Optional build macro OFM_RELU_EN: clamp negative words to zero before packing.
module ofm_stream_reader #(
   parameter int DATA_WIDTH  = 8,
   parameter int INOUT_WIDTH = 128,
   parameter int IFM_SIZE    = 34,
   parameter int KERNEL_SIZE = 3,
   parameter int NO_FILTER   = 16,
   parameter int ADDR_WIDTH  = 14
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   output logic                    rd_en,
   output logic [ADDR_WIDTH-1:0]   rd_addr,
   input  logic [2*DATA_WIDTH-1:0] rd_data,
   output logic [INOUT_WIDTH-1:0]  out_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    out_last,
   output logic                    busy,
   output logic                    done
);

   localparam int WORD_W   = 2 * DATA_WIDTH;
   localparam int WPB      = INOUT_WIDTH / WORD_W;
   localparam int OFM_SIZE = IFM_SIZE - KERNEL_SIZE + 1;
   localparam int TOTAL    = OFM_SIZE * OFM_SIZE * NO_FILTER;
   localparam int BEATS    = TOTAL / WPB;
   localparam int CW       = $clog2(2 * WPB + 1) + 1;
   localparam int BW       = $clog2(BEATS + 1);

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(TOTAL - 1);
   localparam logic [CW-1:0]         CAP_ONE   = CW'(WPB);
   localparam logic [CW-1:0]         CAP_TWO   = CW'(2 * WPB);
   localparam logic [BW-1:0]         LAST_BEAT = BW'(BEATS - 1);

   typedef enum logic [1:0] {IDLE, READ, DRAIN, FIN} state_t;

   state_t                  state_reg;
   logic [ADDR_WIDTH-1:0]   addr_cnt_reg;   // next address to issue
   logic                    dv_reg;         // rd_data carries a word this cycle
   logic [CW-1:0]           pack_cnt_reg;   // filled pack slots
   logic [INOUT_WIDTH-1:0]  pack_reg;
   logic [BW-1:0]           beat_cnt_reg;

   logic [WORD_W-1:0]       word;
   logic                    hs;
   logic                    move;
   logic                    ov_next;
   logic                    room;
   logic [CW-1:0]           filled;
   logic [CW-1:0]           pack_cnt_next;
   logic [CW-1:0]           cap;
   logic [INOUT_WIDTH-1:0]  merged;

   // Next-state helpers: capture, pack-to-output move and read credit.
   // Pack plus output register hold 2*WPB words while the output register is
   // empty; once it is full only the pack (WPB words) can absorb returns.
   always_comb begin
      word = rd_data;
`ifdef OFM_RELU_EN
      if (rd_data[WORD_W-1]) word = '0;
`endif
      hs            = out_valid & out_ready;
      filled        = pack_cnt_reg + CW'(dv_reg);
      move          = (filled == CAP_ONE) & (~out_valid | hs);
      ov_next       = move | (out_valid & ~hs);
      pack_cnt_next = move ? '0 : filled;
      cap           = ov_next ? CAP_ONE : CAP_TWO;
      room          = (pack_cnt_next + CW'(rd_en)) < cap;
   end

   // Pack image with the arriving word dropped into its slot; the final word
   // of a beat goes straight to out_data through this path.
   generate
      for (genvar gi = 0; gi < WPB; gi++) begin : g_slot
         assign merged[gi*WORD_W +: WORD_W] =
            (dv_reg && (pack_cnt_reg == CW'(gi))) ? word : pack_reg[gi*WORD_W +: WORD_W];
      end
   endgenerate

   // Control FSM, read issue, packing and the registered output stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= IDLE;
         addr_cnt_reg <= '0;
         dv_reg       <= 1'b0;
         pack_cnt_reg <= '0;
         pack_reg     <= '0;
         beat_cnt_reg <= '0;
         rd_en        <= 1'b0;
         rd_addr      <= '0;
         out_data     <= '0;
         out_valid    <= 1'b0;
         out_last     <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
      end else begin
         dv_reg       <= rd_en;
         pack_cnt_reg <= pack_cnt_next;
         out_valid    <= ov_next;
         done         <= 1'b0;
         if (dv_reg) pack_reg <= merged;
         if (move) begin
            out_data     <= merged;
            out_last     <= (beat_cnt_reg == LAST_BEAT);
            beat_cnt_reg <= beat_cnt_reg + 1'b1;
         end else if (hs) begin
            out_last <= 1'b0;
         end

         case (state_reg)
            IDLE: begin
               rd_en <= 1'b0;
               if (start) begin
                  state_reg    <= READ;
                  busy         <= 1'b1;
                  rd_en        <= 1'b1;
                  rd_addr      <= '0;
                  addr_cnt_reg <= ADDR_WIDTH'(1);
                  pack_cnt_reg <= '0;
                  beat_cnt_reg <= '0;
               end
            end
            READ: begin
               if (room) begin
                  rd_en        <= 1'b1;
                  rd_addr      <= addr_cnt_reg;
                  addr_cnt_reg <= addr_cnt_reg + 1'b1;
                  if (addr_cnt_reg == LAST_ADDR) state_reg <= DRAIN;
               end else begin
                  rd_en <= 1'b0;
               end
            end
            DRAIN: begin
               rd_en <= 1'b0;
               if (hs && out_last) begin
                  state_reg <= FIN;
                  busy      <= 1'b0;
                  done      <= 1'b1;
               end
            end
            FIN: begin
               rd_en     <= 1'b0;
               state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ofm_stream_reader.sv
// Self-checking bench for ofm_stream_reader: RAM model, randomized ready,
// reference beats computed straight from the memory image.
`timescale 1ns/1ps
module tb_ofm_stream_reader;

   localparam int TOTAL = 16384;
   localparam int WPB   = 8;
   localparam int BEATS = TOTAL / WPB;
`ifdef OFM_RELU_EN
   localparam logic [15:0] SLOT5_EXP = 16'h0000;
`else
   localparam logic [15:0] SLOT5_EXP = 16'hFF38;
`endif

   logic         clk = 1'b0;
   logic         rst_n, start, rd_en, out_valid, out_ready, out_last, busy, done;
   logic [13:0]  rd_addr;
   logic [15:0]  rd_data;
   logic [127:0] out_data;
   logic [15:0]  mem [TOTAL];
   int           n_cmp = 0;
   int           n_bad = 0;

   always #5 clk = ~clk;

   ofm_stream_reader dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_last(out_last), .busy(busy), .done(done)
   );

   // Synchronous-read RAM: data one cycle after rd_en
   always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] exp_word(input int a);
      logic [15:0] w;
      w = mem[a];
`ifdef OFM_RELU_EN
      if (w[15]) w = 16'h0000;
`endif
      return w;
   endfunction

   function automatic logic [127:0] exp_beat(input int b);
      logic [127:0] r;
      for (int k = 0; k < WPB; k++) r[k*16 +: 16] = exp_word(b * WPB + k);
      return r;
   endfunction

   // mode 0: ready high, 1: random ready, 2: ready low 100 cycles at first beat
   task automatic run_drain(input string name, input int mode, input int restart_at,
                            input int abort_beat, input bit slot5_check);
      int e, beats, next_rd, nreads, first_valid_e, fin_e, stall_reads;
      bit exp_done_now, prev_stall, r;
      logic [127:0] prev_data;
      logic prev_last;
      beats = 0; next_rd = 0; nreads = 0; first_valid_e = -1; fin_e = -1;
      stall_reads = 0; exp_done_now = 0; prev_stall = 0; prev_data = '0; prev_last = 0;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      e = 0;
      while (1) begin
         if (rd_en) begin
            chk("rd_addr", 128'(rd_addr), 128'(next_rd));
            next_rd++; nreads++;
         end
         if (mode == 0 && e == 0) begin
            chk("first_rd", 128'({rd_en, rd_addr}), 128'({1'b1, 14'd0}));
            chk("busy_start", 128'(busy), 128'(1));
         end
         if (out_valid && first_valid_e < 0) begin
            first_valid_e = e;
            if (mode == 0) chk("first_valid_edge", 128'(e), 128'(9));
         end
         if (mode == 2 && first_valid_e >= 0) begin
            if (e > first_valid_e && e <= first_valid_e + 100 && rd_en) stall_reads++;
            if (e == first_valid_e + 100) begin
               chk("stall_no_rd", 128'(rd_en), 128'(0));
               chk("stall_reads_max", 128'(stall_reads <= 8), 128'(1));
            end
         end
         chk("done", 128'(done), 128'(exp_done_now));
         if (exp_done_now) begin
            chk("busy_at_done", 128'(busy), 128'(0));
            if (mode == 0) chk("done_edge", 128'(e), 128'(TOTAL + 2));
            fin_e = e;
         end
         if (prev_stall)
            chk("stall_hold", {out_valid, out_last, out_data[125:0]},
                {1'b1, prev_last, prev_data[125:0]});
         if (mode == 0) r = 1'b1;
         else if (mode == 1) r = 1'($urandom_range(0, 1));
         else r = (first_valid_e >= 0 && e < first_valid_e + 100) ? 1'b0 : 1'b1;
         out_ready = r;
         exp_done_now = 0;
         if (out_valid && out_ready) begin
            chk("beat_data", out_data, exp_beat(beats));
            chk("beat_last", 128'(out_last), 128'(beats == BEATS - 1));
            if (mode == 0 && beats == 0)
               chk("beat0_const", out_data, 128'h0007_0006_0005_0004_0003_0002_0001_0000);
            if (slot5_check && beats == 0)
               chk("slot5", 128'(out_data[95:80]), 128'(SLOT5_EXP));
            if (beats == BEATS - 1) exp_done_now = 1;
            beats++;
         end
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
         prev_last  = out_last;
         if (abort_beat > 0 && beats == abort_beat) begin
            rst_n = 1'b0;
            #1;
            chk("abort_outs", 128'({out_valid, busy, done, rd_en}), 128'(0));
            repeat (3) @(negedge clk);
            rst_n = 1'b1;
            for (int i = 0; i < 10; i++) begin
               @(negedge clk);
               chk("after_abort", 128'({out_valid, busy, done, rd_en}), 128'(0));
            end
            $display("run %s: aborted after %0d beats, %0d reads", name, beats, nreads);
            return;
         end
         if (fin_e >= 0 && e == fin_e + 1) break;
         start = (e == restart_at) ? 1'b1 : 1'b0;
         @(negedge clk);
         e++;
         if (e > 40000) begin
            n_cmp++; n_bad++;
            $error("FAIL timeout %s: observed %0d beats expected %0d", name, beats, BEATS);
            return;
         end
      end
      chk("beat_count", 128'(beats), 128'(BEATS));
      chk("read_count", 128'(nreads), 128'(TOTAL));
      $display("run %s: beats=%0d reads=%0d edges=%0d", name, beats, nreads, e);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; out_ready = 1'b0; rd_data = '0;
      repeat (3) @(negedge clk);
      chk("reset_ctl", 128'({rd_en, rd_addr, out_valid, out_last, busy, done}), 128'(0));
      chk("reset_data", out_data, 128'(0));
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle_ctl", 128'({rd_en, out_valid, busy, done}), 128'(0));

      for (int i = 0; i < TOTAL; i++) mem[i] = 16'(i);
      run_drain("ramp_ready", 0, -1, 0, 1'b0);

      for (int i = 0; i < TOTAL; i++) mem[i] = 16'(i * 3);
      run_drain("x3_random_ready", 1, -1, 0, 1'b0);

      for (int i = 0; i < TOTAL; i++) mem[i] = 16'($urandom);
      run_drain("stall_and_restart_pulse", 2, 5000, 0, 1'b0);

      run_drain("abort_at_500", 1, -1, 500, 1'b0);

      for (int i = 0; i < TOTAL; i++) mem[i] = 16'(i);
      mem[5] = 16'hFF38;
      run_drain("restart_negative_slot5", 1, -1, 20, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
